// File: rtl/mdu_div_ctrl.sv
// Divide front/back end around the 32-cycle unsigned core: 34-cycle latency via the core, 1 for special cases or cache hits.
// Stalls EX while an op is pending; optional result cache enabled by DIV_RESULT_CACHE_EN.
module mdu_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [1:0]      ex_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stallreq,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            div_in_valid,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic            div_busy,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            sgn_q, rem_q, q_neg_q, r_neg_q;

  logic            op_signed, op_rem, div_by_zero, overflow, special;
  logic [XLEN-1:0] special_res, q_fix, r_fix, core_res;
  logic            cache_hit;
  logic [XLEN-1:0] hit_res;

  assign op_signed = ~ex_op[0];
  assign op_rem    = ex_op[1];

  assign div_a = (op_signed & rs1[XLEN-1]) ? -rs1 : rs1;
  assign div_b = (op_signed & rs2[XLEN-1]) ? -rs2 : rs2;

  assign div_by_zero = (rs2 == '0);
  assign overflow    = op_signed & (rs1 == INT_MIN) & (rs2 == '1);
  assign special     = div_by_zero | overflow;
  assign special_res = op_rem ? (div_by_zero ? rs1 : '0)
                              : (div_by_zero ? '1 : INT_MIN);

  assign q_fix    = (sgn_q & q_neg_q) ? -div_quotient  : div_quotient;
  assign r_fix    = (sgn_q & r_neg_q) ? -div_remainder : div_remainder;
  assign core_res = rem_q ? r_fix : q_fix;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld_q, cache_sgn_q;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q, cache_quo_q, cache_rem_q;

  // EX operands are still held here because stallreq stays high through WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
    end else if (!flush && state_q == WAIT && !div_busy) begin
      cache_vld_q <= 1'b1;
      cache_sgn_q <= sgn_q;
      cache_rs1_q <= rs1;
      cache_rs2_q <= rs2;
      cache_quo_q <= q_fix;
      cache_rem_q <= r_fix;
    end
  end

  assign cache_hit = cache_vld_q & (rs1 == cache_rs1_q) & (rs2 == cache_rs2_q)
                   & (op_signed == cache_sgn_q);
  assign hit_res   = op_rem ? cache_rem_q : cache_quo_q;
`else
  assign cache_hit = 1'b0;
  assign hit_res   = '0;
`endif

  assign result_d = (state_q == IDLE) ? (special ? special_res : hit_res) : core_res;

  // Single-cycle start only from IDLE; a held level would reload a finished core.
  assign div_in_valid = (state_q == IDLE) & ex_valid & ~special & ~cache_hit
                      & ~div_busy & ~flush;
  assign stallreq     = ~flush & (((state_q == IDLE) & ex_valid) | (state_q == WAIT));
  assign result_valid = (state_q == DONE) & ~flush;
  assign result       = result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      sgn_q    <= 1'b0;
      rem_q    <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (special || cache_hit) begin
              result_q <= result_d;
              state_q  <= DONE;
            end else if (!div_busy) begin
              sgn_q   <= op_signed;
              rem_q   <= op_rem;
              q_neg_q <= rs1[XLEN-1] ^ rs2[XLEN-1];
              r_neg_q <= rs1[XLEN-1];
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!div_busy) begin
            result_q <= result_d;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed bench for mdu_div_ctrl with a behavioural 32-cycle divider core model.
module tb_mdu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_valid;
  logic [1:0]  ex_op;
  logic [31:0] rs1, rs2;
  logic        stallreq, result_valid, div_in_valid, div_busy;
  logic [31:0] result, div_a, div_b, div_quotient, div_remainder;

  int checks = 0;
  int fails  = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1, HIT_PAT = -1, HIT_PULSES = 0;
`else
  localparam int HIT_LAT = 34, HIT_PAT = 0, HIT_PULSES = 1;
`endif

  always #5 clk = ~clk;

  mdu_div_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op),
    .rs1(rs1), .rs2(rs2), .stallreq(stallreq), .result_valid(result_valid),
    .result(result), .div_in_valid(div_in_valid), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // Core model: loads on the pulse, counts 32..0, outputs are garbage until the count ends.
  logic [5:0]  cnt;
  logic [31:0] pa, pb;
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 6'd0;
      div_quotient  <= 32'hDEADBEEF;
      div_remainder <= 32'hDEADBEEF;
    end else if (div_in_valid) begin
      cnt <= 6'd32;
      pa  <= div_a;
      pb  <= div_b;
      div_quotient  <= 32'hDEADBEEF;
      div_remainder <= 32'hDEADBEEF;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
      if (cnt == 6'd1) begin
        div_quotient  <= (pb == 32'd0) ? 32'hFFFFFFFF : pa / pb;
        div_remainder <= (pb == 32'd0) ? pa : pa % pb;
      end
    end
  end
  assign div_busy = (cnt != 6'd0);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle the current EX inputs were first presented.
  task automatic wait_result(string tag, int exp_lat, int exp_pat, int exp_pulses,
                             logic [31:0] exp_res);
    int n, pulses, pat;
    bit stall_bad, got;
    n = 0; pulses = 0; pat = -1; stall_bad = 1'b0; got = 1'b0;
    while (n <= 200) begin
      if (result_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (div_in_valid === 1'b1) begin
        pulses++;
        if (pat < 0) pat = n;
      end
      if (stallreq !== 1'b1) stall_bad = 1'b1;
      tick();
      n++;
    end
    check({tag, ":got_result"}, 32'(got), 32'd1);
    check({tag, ":latency"}, n, exp_lat);
    check({tag, ":result"}, result, exp_res);
    check({tag, ":stall_low_at_done"}, 32'(stallreq), 32'd0);
    check({tag, ":stall_held"}, 32'(stall_bad), 32'd0);
    check({tag, ":pulses"}, pulses, exp_pulses);
    check({tag, ":pulse_cycle"}, pat, exp_pat);
    tick();
    ex_valid = 1'b0;
    #1;
    check({tag, ":valid_one_cycle"}, 32'(result_valid), 32'd0);
    check({tag, ":result_held"}, result, exp_res);
  endtask

  task automatic do_op(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       int lat, int pat, int pulses, logic [31:0] exp_res);
    ex_op = op; rs1 = a; rs2 = b; ex_valid = 1'b1;
    #1;
    wait_result(tag, lat, pat, pulses, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_op = OP_DIV; rs1 = '0; rs2 = '0;
    repeat (3) tick();
    check("reset:result", result, 32'd0);
    check("reset:result_valid", 32'(result_valid), 32'd0);
    check("reset:div_in_valid", 32'(div_in_valid), 32'd0);
    check("reset:stallreq", 32'(stallreq), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 34, 0, 1, 32'd14);
    do_op("div_100_7",   OP_DIV,  32'd100, 32'd7, 34, 0, 1, 32'd14);
    do_op("rem_100_7",   OP_REM,  32'd100, 32'd7, HIT_LAT, HIT_PAT, HIT_PULSES, 32'd2);
    do_op("div_m7_2",    OP_DIV,  32'hFFFFFFF9, 32'd2, 34, 0, 1, 32'hFFFFFFFD);
    do_op("rem_m7_2",    OP_REM,  32'hFFFFFFF9, 32'd2, HIT_LAT, HIT_PAT, HIT_PULSES, 32'hFFFFFFFF);
    do_op("remu_f9_2",   OP_REMU, 32'hFFFFFFF9, 32'd2, 34, 0, 1, 32'd1);
    do_op("divu_5_0",    OP_DIVU, 32'd5, 32'd0, 1, -1, 0, 32'hFFFFFFFF);
    do_op("rem_5_0",     OP_REM,  32'd5, 32'd0, 1, -1, 0, 32'd5);
    do_op("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1, -1, 0, 32'h80000000);
    do_op("rem_ovf",     OP_REM,  32'h80000000, 32'hFFFFFFFF, 1, -1, 0, 32'd0);
    do_op("divu_no_ovf", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 34, 0, 1, 32'd0);
    do_op("div_7_m2",    OP_DIV,  32'd7, 32'hFFFFFFFE, 34, 0, 1, 32'hFFFFFFFD);
    do_op("rem_7_m2",    OP_REM,  32'd7, 32'hFFFFFFFE, HIT_LAT, HIT_PAT, HIT_PULSES, 32'd1);

    // Flush a running op; the next one must wait for the core to drain.
    ex_op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; ex_valid = 1'b1;
    #1;
    check("flush:start_pulse", 32'(div_in_valid), 32'd1);
    repeat (10) tick();
    flush = 1'b1;
    #1;
    check("flush:stall_low", 32'(stallreq), 32'd0);
    check("flush:no_valid", 32'(result_valid), 32'd0);
    tick();
    flush = 1'b0; rs1 = 32'd9; rs2 = 32'd3;
    #1;
    wait_result("after_flush", 56, 22, 1, 32'd3);

    // Reset mid-operation returns to IDLE, clears result and the cache.
    ex_op = OP_DIV; rs1 = 32'd50; rs2 = 32'd5; ex_valid = 1'b1;
    #1;
    repeat (5) tick();
    rst_n = 1'b0; ex_valid = 1'b0;
    tick();
    check("midreset:result", result, 32'd0);
    check("midreset:result_valid", 32'(result_valid), 32'd0);
    check("midreset:stallreq", 32'(stallreq), 32'd0);
    rst_n = 1'b1;
    tick();
    do_op("post_reset_divu_9_3", OP_DIVU, 32'd9, 32'd3, 34, 0, 1, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
